// File: rtl/fb_arbiter_pkg.sv
// Shared definitions for the framebuffer arbiter: geometry, clear-engine
// states and the grant-source encoding used by the slot arbiter.
package fb_pkg;

    localparam int ADDR_W   = 17;
    localparam int DATA_W   = 12;
    localparam int FB_DEPTH = 76800;

    typedef enum logic {
        IDLE,
        FILL
    } clr_state_e;

    typedef enum logic [1:0] {
        G_NONE,
        G_RD,
        G_CLR,
        G_WR
    } grant_e;

    function automatic logic in_range(input logic [ADDR_W-1:0] addr);
        return addr < ADDR_W'(FB_DEPTH);
    endfunction

endpackage

// File: rtl/fb_arbiter_if.sv
// Framebuffer arbiter bus: VGA read port, external write port, clear
// control and the single-port BRAM port.
//   master : requesters and RAM (drive requests / ram_rdata)
//   slave  : the arbiter (drives results, handshakes and RAM controls)
interface fb_arbiter_if;
    import fb_pkg::*;

    logic              rd_req;
    logic [ADDR_W-1:0] rd_addr;
    logic [DATA_W-1:0] rd_data;
    logic              rd_valid;

    logic              wr_valid;
    logic              wr_ready;
    logic [ADDR_W-1:0] wr_addr;
    logic [DATA_W-1:0] wr_data;

    logic              clr_start;
    logic [DATA_W-1:0] clr_color;
    logic              clr_busy;
    logic              clr_done;

    logic              ram_en;
    logic              ram_we;
    logic [ADDR_W-1:0] ram_addr;
    logic [DATA_W-1:0] ram_wdata;
    logic [DATA_W-1:0] ram_rdata;

    modport master (
        output rd_req, rd_addr, wr_valid, wr_addr, wr_data,
               clr_start, clr_color, ram_rdata,
        input  rd_data, rd_valid, wr_ready, clr_busy, clr_done,
               ram_en, ram_we, ram_addr, ram_wdata
    );

    modport slave (
        input  rd_req, rd_addr, wr_valid, wr_addr, wr_data,
               clr_start, clr_color, ram_rdata,
        output rd_data, rd_valid, wr_ready, clr_busy, clr_done,
               ram_en, ram_we, ram_addr, ram_wdata
    );

endinterface

// File: rtl/fb_arbiter_clear.sv
// Bulk-fill engine: walks addresses 0..FB_DEPTH-1 writing a latched colour,
// advancing only on cycles where the arbiter grants it the slot.
//   clk_i, rst_i          : clock, async active-high reset
//   clr_start_i/color_i   : start pulse and fill colour (sampled in IDLE)
//   grant_i               : clear owns the RAM slot this cycle
//   clr_req_o/addr_o/data_o : slot request with the word to write
//   clr_busy_o, clr_done_o  : fill in progress, one-cycle completion pulse
//
// state | meaning
// IDLE  | no fill running, waiting for clr_start
// FILL  | writing colour at counter on every granted cycle
module fb_clear_fsm
    import fb_pkg::*;
(
    input  logic              clk_i,
    input  logic              rst_i,
    input  logic              clr_start_i,
    input  logic [DATA_W-1:0] clr_color_i,
    input  logic              grant_i,
    output logic              clr_req_o,
    output logic [ADDR_W-1:0] clr_addr_o,
    output logic [DATA_W-1:0] clr_data_o,
    output logic              clr_busy_o,
    output logic              clr_done_o
);

    localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(FB_DEPTH - 1);

    clr_state_e        state_q, state_d;
    logic [ADDR_W-1:0] cnt_q, cnt_d;
    logic [DATA_W-1:0] color_q, color_d;
    logic              done_q, done_d;

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            color_q <= '0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            color_q <= color_d;
            done_q  <= done_d;
        end
    end

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        color_d = color_q;
        done_d  = 1'b0;
        case (state_q)
            IDLE: begin
                if (clr_start_i) begin
                    state_d = FILL;
                    cnt_d   = '0;
                    color_d = clr_color_i;
                end
            end
            FILL: begin
                // clr_start is deliberately not looked at here
                if (grant_i) begin
                    if (cnt_q == LAST_ADDR) begin
                        state_d = IDLE;
                        cnt_d   = '0;
                        done_d  = 1'b1;
                    end else begin
                        cnt_d = cnt_q + 1'b1;
                    end
                end
            end
            default: state_d = IDLE;
        endcase
    end

    assign clr_req_o  = (state_q == FILL);
    assign clr_busy_o = (state_q == FILL);
    assign clr_addr_o = cnt_q;
    assign clr_data_o = color_q;
    assign clr_done_o = done_q;

endmodule

// File: rtl/fb_arbiter.sv
// Single-port framebuffer arbiter. Priority per cycle: VGA read, then the
// clear engine, then external writes. RAM controls are registered one
// cycle after the grant; reads return with a fixed 3-cycle latency.
//   clk_25 : pixel clock
//   rst    : async active-high reset
//   fb_if  : request ports, handshakes and BRAM port (slave modport)
module fb_arbiter
    import fb_pkg::*;
(
    input  logic         clk_25,
    input  logic         rst,
    fb_arbiter_if.slave  fb_if
);

    grant_e            gnt;
    logic              clr_req;
    logic [ADDR_W-1:0] clr_addr;
    logic [DATA_W-1:0] clr_data;
    logic              clr_busy;

    logic              ram_en_q, ram_en_d;
    logic              ram_we_q, ram_we_d;
    logic [ADDR_W-1:0] ram_addr_q, ram_addr_d;
    logic [DATA_W-1:0] ram_wdata_q, ram_wdata_d;

    // Read pipeline: stage 1 = RAM access cycle, stage 2 = ram_rdata cycle.
    // The out-of-range flag travels along so the result can be forced to 0.
    logic              p1_vld_q, p1_oor_q, p2_vld_q, p2_oor_q;
    logic              rd_valid_q;
    logic [DATA_W-1:0] rd_data_q, rd_data_d;

    fb_clear_fsm u_clear (
        .clk_i       (clk_25),
        .rst_i       (rst),
        .clr_start_i (fb_if.clr_start),
        .clr_color_i (fb_if.clr_color),
        .grant_i     (gnt == G_CLR),
        .clr_req_o   (clr_req),
        .clr_addr_o  (clr_addr),
        .clr_data_o  (clr_data),
        .clr_busy_o  (clr_busy),
        .clr_done_o  (fb_if.clr_done)
    );

    always_comb begin
        gnt = G_NONE;
        if (fb_if.rd_req)        gnt = G_RD;
        else if (clr_req)        gnt = G_CLR;
        else if (fb_if.wr_valid) gnt = G_WR;
    end

    always_comb begin
        ram_en_d    = 1'b0;
        ram_we_d    = 1'b0;
        ram_addr_d  = ram_addr_q;
        ram_wdata_d = ram_wdata_q;
        case (gnt)
            G_RD: begin
                ram_en_d   = in_range(fb_if.rd_addr);
                ram_addr_d = fb_if.rd_addr;
            end
            G_CLR: begin
                ram_en_d    = 1'b1;
                ram_we_d    = 1'b1;
                ram_addr_d  = clr_addr;
                ram_wdata_d = clr_data;
            end
            G_WR: begin
                // out-of-range writes complete the handshake but are dropped
                ram_en_d    = in_range(fb_if.wr_addr);
                ram_we_d    = in_range(fb_if.wr_addr);
                ram_addr_d  = fb_if.wr_addr;
                ram_wdata_d = fb_if.wr_data;
            end
            default: ;
        endcase
    end

    always_comb begin
        rd_data_d = rd_data_q;
        if (p2_vld_q) rd_data_d = p2_oor_q ? '0 : fb_if.ram_rdata;
    end

    always_ff @(posedge clk_25 or posedge rst) begin
        if (rst) begin
            ram_en_q    <= 1'b0;
            ram_we_q    <= 1'b0;
            ram_addr_q  <= '0;
            ram_wdata_q <= '0;
            p1_vld_q    <= 1'b0;
            p1_oor_q    <= 1'b0;
            p2_vld_q    <= 1'b0;
            p2_oor_q    <= 1'b0;
            rd_valid_q  <= 1'b0;
            rd_data_q   <= '0;
        end else begin
            ram_en_q    <= ram_en_d;
            ram_we_q    <= ram_we_d;
            ram_addr_q  <= ram_addr_d;
            ram_wdata_q <= ram_wdata_d;
            p1_vld_q    <= (gnt == G_RD);
            p1_oor_q    <= !in_range(fb_if.rd_addr);
            p2_vld_q    <= p1_vld_q;
            p2_oor_q    <= p1_oor_q;
            rd_valid_q  <= p2_vld_q;
            rd_data_q   <= rd_data_d;
        end
    end

    assign fb_if.wr_ready  = !rst && !fb_if.rd_req && !clr_busy;
    assign fb_if.clr_busy  = clr_busy;
    assign fb_if.ram_en    = ram_en_q;
    assign fb_if.ram_we    = ram_we_q;
    assign fb_if.ram_addr  = ram_addr_q;
    assign fb_if.ram_wdata = ram_wdata_q;
    assign fb_if.rd_valid  = rd_valid_q;
    assign fb_if.rd_data   = rd_data_q;

endmodule

// File: tb/tb_fb_arbiter.sv
// Bench for fb_arbiter: table of single-cycle arbitration vectors plus
// hand-written sequences for read latency, bulk fill and reset abort.
module tb_fb_arbiter;

    logic clk_25 = 1'b0;
    logic rst    = 1'b1;
    int   total  = 0;
    int   bad    = 0;

    fb_arbiter_if fb_if();

    fb_arbiter dut (
        .clk_25 (clk_25),
        .rst    (rst),
        .fb_if  (fb_if)
    );

    always #5 clk_25 = ~clk_25;

    // BRAM model, 1-cycle read latency
    logic [11:0] mem [0:76799];
    logic [11:0] ram_q = '0;
    assign fb_if.ram_rdata = ram_q;
    always @(posedge clk_25) begin
        if (fb_if.ram_en) begin
            if (fb_if.ram_we) mem[fb_if.ram_addr] <= fb_if.ram_wdata;
            ram_q <= mem[fb_if.ram_addr];
        end
    end

    typedef struct {
        logic        rd_req;
        logic [16:0] rd_addr;
        logic        wr_valid;
        logic [16:0] wr_addr;
        logic [11:0] wr_data;
        logic        exp_rdy;
        logic        exp_en;
        logic        exp_we;
        logic [16:0] exp_addr;
        logic [11:0] exp_wdata;
    } vec_t;

    vec_t vecs [7];

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h want %0h", nm, act, exp);
        end
    endtask

    task automatic idle_inputs();
        fb_if.rd_req    = 1'b0;
        fb_if.rd_addr   = '0;
        fb_if.wr_valid  = 1'b0;
        fb_if.wr_addr   = '0;
        fb_if.wr_data   = '0;
        fb_if.clr_start = 1'b0;
        fb_if.clr_color = '0;
    endtask

    // one read at a negedge; checks the 3-cycle latency and the data
    task automatic do_read(input string nm, input logic [16:0] a, input logic [11:0] exp);
        @(negedge clk_25);
        fb_if.rd_req  = 1'b1;
        fb_if.rd_addr = a;
        @(negedge clk_25);
        fb_if.rd_req = 1'b0;
        chk({nm, "_v1"}, 32'(fb_if.rd_valid), 0);
        @(negedge clk_25);
        chk({nm, "_v2"}, 32'(fb_if.rd_valid), 0);
        @(negedge clk_25);
        chk({nm, "_v3"}, 32'(fb_if.rd_valid), 1);
        chk({nm, "_data"}, 32'(fb_if.rd_data), 32'(exp));
    endtask

    initial begin
        logic [16:0] raddr [4];
        logic [11:0] rexp  [4];
        int busy_n, done_n, rdy_n, guard;

        idle_inputs();
        vecs[0] = '{0, 0,     1, 5,     12'hABC, 1, 1, 1, 5,     12'hABC};
        vecs[1] = '{1, 5,     1, 6,     12'h111, 0, 1, 0, 5,     12'h000};
        vecs[2] = '{0, 0,     0, 0,     12'h000, 1, 0, 0, 0,     12'h000};
        vecs[3] = '{0, 0,     1, 76800, 12'hFFF, 1, 0, 0, 0,     12'h000};
        vecs[4] = '{1, 76800, 0, 0,     12'h000, 0, 0, 0, 0,     12'h000};
        vecs[5] = '{0, 0,     1, 76799, 12'h123, 1, 1, 1, 76799, 12'h123};
        vecs[6] = '{1, 76799, 0, 0,     12'h000, 0, 1, 0, 76799, 12'h000};

        // reset state
        repeat (2) @(negedge clk_25);
        chk("rst_rd_valid", 32'(fb_if.rd_valid), 0);
        chk("rst_rd_data",  32'(fb_if.rd_data), 0);
        chk("rst_ram_en",   32'(fb_if.ram_en), 0);
        chk("rst_ram_we",   32'(fb_if.ram_we), 0);
        chk("rst_ram_addr", 32'(fb_if.ram_addr), 0);
        chk("rst_clr_busy", 32'(fb_if.clr_busy), 0);
        chk("rst_clr_done", 32'(fb_if.clr_done), 0);
        fb_if.wr_valid = 1'b1;
        #1 chk("rst_wr_ready", 32'(fb_if.wr_ready), 0);
        fb_if.wr_valid = 1'b0;
        @(negedge clk_25);
        rst = 1'b0;

        // arbitration vectors
        for (int i = 0; i < 7; i++) begin
            fb_if.rd_req   = vecs[i].rd_req;
            fb_if.rd_addr  = vecs[i].rd_addr;
            fb_if.wr_valid = vecs[i].wr_valid;
            fb_if.wr_addr  = vecs[i].wr_addr;
            fb_if.wr_data  = vecs[i].wr_data;
            #1 chk($sformatf("v%0d_wr_ready", i), 32'(fb_if.wr_ready), 32'(vecs[i].exp_rdy));
            @(negedge clk_25);
            chk($sformatf("v%0d_ram_en", i), 32'(fb_if.ram_en), 32'(vecs[i].exp_en));
            chk($sformatf("v%0d_ram_we", i), 32'(fb_if.ram_we), 32'(vecs[i].exp_we));
            if (vecs[i].exp_en)
                chk($sformatf("v%0d_ram_addr", i), 32'(fb_if.ram_addr), 32'(vecs[i].exp_addr));
            if (vecs[i].exp_we)
                chk($sformatf("v%0d_ram_wdata", i), 32'(fb_if.ram_wdata), 32'(vecs[i].exp_wdata));
        end
        idle_inputs();
        repeat (4) @(negedge clk_25);

        do_read("rd5", 17'd5, 12'hABC);
        repeat (2) @(negedge clk_25);

        // 4 back-to-back reads while a write waits
        raddr[0] = 17'd5;     rexp[0] = 12'hABC;
        raddr[1] = 17'd76799; rexp[1] = 12'h123;
        raddr[2] = 17'd76800; rexp[2] = 12'h000;
        raddr[3] = 17'd5;     rexp[3] = 12'hABC;
        for (int k = 0; k < 8; k++) begin
            @(negedge clk_25);
            if (k >= 3 && k <= 6) begin
                chk($sformatf("b2b_valid%0d", k - 3), 32'(fb_if.rd_valid), 1);
                chk($sformatf("b2b_data%0d", k - 3), 32'(fb_if.rd_data), 32'(rexp[k-3]));
            end else if (k == 2 || k == 7) begin
                chk($sformatf("b2b_novalid%0d", k), 32'(fb_if.rd_valid), 0);
            end
            if (k == 3) chk("oor_rd_no_en", 32'(fb_if.ram_en), 0);
            if (k < 4) begin
                fb_if.rd_req   = 1'b1;
                fb_if.rd_addr  = raddr[k];
                fb_if.wr_valid = 1'b1;
                fb_if.wr_addr  = 17'd10;
                fb_if.wr_data  = 12'h55A;
                #1 chk($sformatf("b2b_wr_ready%0d", k), 32'(fb_if.wr_ready), 0);
            end else if (k == 4) begin
                fb_if.rd_req = 1'b0;
                #1 chk("b2b_wr_ready_free", 32'(fb_if.wr_ready), 1);
            end else if (k == 5) begin
                chk("b2b_wr_we", 32'(fb_if.ram_we), 1);
                chk("b2b_wr_addr", 32'(fb_if.ram_addr), 10);
                chk("b2b_wr_data", 32'(fb_if.ram_wdata), 32'h55A);
                fb_if.wr_valid = 1'b0;
            end
        end
        do_read("rd10", 17'd10, 12'h55A);

        // full clear with a simultaneous write and a mid-fill clr_start
        @(negedge clk_25);
        fb_if.clr_start = 1'b1;
        fb_if.clr_color = 12'h0F0;
        fb_if.wr_valid  = 1'b1;
        fb_if.wr_addr   = 17'd20;
        fb_if.wr_data   = 12'h777;
        #1 chk("clr_start_wr_ready", 32'(fb_if.wr_ready), 1);
        @(negedge clk_25);
        chk("clr_wr_we", 32'(fb_if.ram_we), 1);
        chk("clr_wr_addr", 32'(fb_if.ram_addr), 20);
        chk("clr_wr_data", 32'(fb_if.ram_wdata), 32'h777);
        chk("clr_busy_t1", 32'(fb_if.clr_busy), 1);
        fb_if.clr_start = 1'b0;
        fb_if.clr_color = 12'h00F;
        fb_if.wr_valid  = 1'b0;
        busy_n = 1;
        done_n = 0;
        rdy_n  = 0;
        guard  = 0;
        @(negedge clk_25);
        chk("clr_first_addr", 32'(fb_if.ram_addr), 0);
        chk("clr_first_we", 32'(fb_if.ram_we), 1);
        chk("clr_first_data", 32'(fb_if.ram_wdata), 32'h0F0);
        busy_n++;
        fb_if.wr_valid = 1'b1;
        while (guard <= 80000) begin
            @(negedge clk_25);
            guard++;
            if (fb_if.clr_done) done_n++;
            if (!fb_if.clr_busy) break;
            busy_n++;
            if (fb_if.wr_ready) rdy_n++;
            fb_if.clr_start = (guard == 100);
        end
        fb_if.wr_valid = 1'b0;
        fb_if.clr_start = 1'b0;
        chk("clr_timeout", 32'(guard <= 80000), 1);
        chk("clr_busy_cycles", 32'(busy_n), 76800);
        chk("clr_done_at_end", 32'(fb_if.clr_done), 1);
        chk("clr_last_addr", 32'(fb_if.ram_addr), 76799);
        chk("clr_last_data", 32'(fb_if.ram_wdata), 32'h0F0);
        chk("clr_wr_ready_low", 32'(rdy_n), 0);
        @(negedge clk_25);
        chk("clr_done_pulse", 32'(fb_if.clr_done), 0);
        chk("clr_done_count", 32'(done_n), 1);
        do_read("clr_rd0", 17'd0, 12'h0F0);
        do_read("clr_rd_last", 17'd76799, 12'h0F0);

        // reset mid-fill
        @(negedge clk_25);
        fb_if.clr_start = 1'b1;
        fb_if.clr_color = 12'h333;
        @(negedge clk_25);
        fb_if.clr_start = 1'b0;
        guard = 0;
        while (!(fb_if.ram_we && fb_if.ram_addr == 17'd1000) && guard < 2000) begin
            @(negedge clk_25);
            guard++;
        end
        chk("abort_reach_1000", 32'(guard < 2000), 1);
        rst = 1'b1;
        #1;
        chk("abort_busy", 32'(fb_if.clr_busy), 0);
        chk("abort_done", 32'(fb_if.clr_done), 0);
        chk("abort_ram_we", 32'(fb_if.ram_we), 0);
        @(negedge clk_25);
        rst = 1'b0;
        done_n = 0;
        repeat (5) begin
            @(negedge clk_25);
            if (fb_if.clr_done) done_n++;
        end
        chk("abort_no_done", 32'(done_n), 0);

        // restart from 0, then a read stalls the counter
        fb_if.clr_start = 1'b1;
        fb_if.clr_color = 12'h444;
        @(negedge clk_25);
        fb_if.clr_start = 1'b0;
        @(negedge clk_25);
        chk("restart_addr0", 32'(fb_if.ram_addr), 0);
        chk("restart_we", 32'(fb_if.ram_we), 1);
        chk("restart_data", 32'(fb_if.ram_wdata), 32'h444);
        #1 chk("fill_wr_ready", 32'(fb_if.wr_ready), 0);
        fb_if.rd_req  = 1'b1;
        fb_if.rd_addr = 17'd0;
        @(negedge clk_25);
        chk("stall_we", 32'(fb_if.ram_we), 0);
        chk("stall_rd_en", 32'(fb_if.ram_en), 1);
        fb_if.rd_req = 1'b0;
        @(negedge clk_25);
        chk("stall_resume_addr", 32'(fb_if.ram_addr), 1);
        chk("stall_resume_we", 32'(fb_if.ram_we), 1);
        @(negedge clk_25);
        chk("fill_rd_valid", 32'(fb_if.rd_valid), 1);
        chk("fill_rd_data", 32'(fb_if.rd_data), 32'h444);

        rst = 1'b1;
        @(negedge clk_25);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
